output_collector: RTL and testbench
===================================

Name: output_collector

Overview:
- Sits directly downstream of the convolution core and consumes its output stream: output_data plus the output_x, output_y and output_ch coordinates, qualified by output_valid.
- The core cannot be back-pressured, so every beat is absorbed into a small FIFO.
- Each beat is written to the output feature-map memory over a valid/ready write port, at a linear channel-major address.
- Counts beats per layer run and signals done once the full map is received and drained.

Parameters:
- DATA_WIDTH, 16: width of one output sample.
- FEATURE_MAP_WIDTH, 128: W, the output map width.
- FEATURE_MAP_HEIGHT, 128: H, the output map height.
- OUTPUT_NB_CHANNELS, 64: C, the output channel count.
- FIFO_DEPTH, 8: number of FIFO entries. Must be a power of 2 and at least 2.
- Derived: ADDR_W = $clog2(W*H*C); CNT_W = $clog2(W*H*C+1).

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- arst_n, input, 1: reset, synchronous, active-low.
- start, input, 1: one-cycle pulse that arms a new layer run.
- in_data, input, DATA_WIDTH: sample from the core (signed).
- in_valid, input, 1: sample and coordinates are valid this cycle. There is no ready signal.
- in_x, input, $clog2(W): column coordinate.
- in_y, input, $clog2(H): row coordinate.
- in_ch, input, $clog2(C): channel coordinate.
- mem_we, output, 1: write request valid.
- mem_addr, output, ADDR_W: write address.
- mem_wdata, output, DATA_WIDTH: write data.
- mem_ready, input, 1: memory accepts the write this cycle.
- busy, output, 1: high in COLLECT or DRAIN.
- done, output, 1: held high in DONE.
- overflow, output, 1: sticky flag; a beat was dropped.
- fifo_count, output, $clog2(FIFO_DEPTH+1): current FIFO occupancy.

Behaviour:
- Reset (arst_n low at a clock edge):
  - State goes to IDLE; FIFO is emptied; beat counter is 0.
  - mem_we=0, busy=0, done=0, overflow=0, fifo_count=0.
  - mem_addr and mem_wdata are 0 while the FIFO is empty.
  - Reset applied mid-run discards all buffered beats with no further writes.
- State machine: IDLE -> COLLECT -> DRAIN -> DONE.
  - IDLE or DONE with start=1: go to COLLECT; clear the beat counter and overflow; done drops on the next cycle.
  - start in COLLECT or DRAIN is ignored.
  - COLLECT: each in_valid beat increments the beat counter. When the counter reaches W*H*C, go to DRAIN on that same edge.
  - DRAIN: go to DONE on the first cycle the FIFO is empty.
  - DONE: wait for start.
- Ingest:
  - A beat is accepted only in COLLECT. in_valid in IDLE, DRAIN or DONE is ignored and not counted.
  - Stored entry = {address, data}, with address = (in_ch*H + in_y)*W + in_x. Compute in ADDR_W bits, unsigned; in_data is stored unmodified.
  - FIFO full with no pop that cycle: the beat is dropped, overflow is set, and the beat is still counted so the run terminates.
  - FIFO full and popping the same cycle: the push is accepted, not dropped.
- Write side:
  - mem_we = FIFO non-empty. mem_addr and mem_wdata come combinationally from the FIFO head.
  - A pop occurs when mem_we && mem_ready.
  - While mem_we=1 and mem_ready=0, the head and its outputs are held stable.
  - Latency: a beat pushed at edge N appears on mem_we/mem_addr/mem_wdata after edge N, i.e. it is writable in cycle N+1.
  - Writes leave in arrival order.
- fifo_count: registered occupancy. Simultaneous push and pop leave it unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit or by the count.
- busy = (state is COLLECT or DRAIN).

Test Plan:
- Reset, then start. Feed 4 beats (x=1,y=0,ch=0,data=5), (x=0,y=1,ch=0,data=-3), (x=0,y=0,ch=1,data=7), (x=127,y=127,ch=63,data=1) with W=H=128, C=64, mem_ready=1 -> writes in order at addr 1, 128, 16384, 1048575 with the same data, each in the cycle after its push; fifo_count never exceeds 1.
- Reduced map W=H=2, C=1, mem_ready=1: start, then 4 beats -> DRAIN, then DONE within 2 cycles of the last beat; done held until the next start; busy low in DONE.
- mem_ready=0 while 8 beats arrive on consecutive cycles -> fifo_count=8, overflow=0. A 9th beat -> overflow=1 and that beat is never written. Then mem_ready=1 -> exactly 8 writes, in order.
- FIFO full with mem_ready=1 and in_valid=1 in the same cycle -> push accepted, fifo_count stays 8, overflow=0.
- in_valid pulses while in IDLE and after DONE -> no counter change and no writes. A start during COLLECT -> ignored, counter not cleared.
- Assert arst_n low with 3 entries buffered and mem_ready=0 -> next cycle state IDLE, fifo_count=0, mem_we=0, and no writes after releasing reset.

Source files
------------

// File: rtl/output_collector.sv
// Collects the convolution core's output beats into a small FIFO and writes them
// to the output feature-map memory at channel-major addresses; flags done per run.
module output_collector #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  input  logic                                   start,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic                                   in_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  in_ch,
  output logic                                   mem_we,
  output logic [$clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]                  mem_wdata,
  input  logic                                   mem_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count
);

  localparam int TOTAL   = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam int ADDR_W  = $clog2(TOTAL);
  localparam int CNT_W   = $clog2(TOTAL + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + DATA_WIDTH;

  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [COUNT_W-1:0] fifoCount_q, fifoCount_d;
  logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];

  logic               fifoEmpty;
  logic               fifoFull;
  logic               beatIn;
  logic               popFire;
  logic               pushFire;
  logic               dropBeat;
  logic [ADDR_W-1:0]  entryAddr;
  logic [ENTRY_W-1:0] headEntry;

  assign entryAddr = (ADDR_W'(in_ch) * ADDR_W'(FEATURE_MAP_HEIGHT) + ADDR_W'(in_y))
                     * ADDR_W'(FEATURE_MAP_WIDTH) + ADDR_W'(in_x);

  // The core cannot stall: a full FIFO only drops a beat if nothing leaves this cycle.
  assign fifoEmpty = (fifoCount_q == '0);
  assign fifoFull  = (fifoCount_q == FULL_COUNT);
  assign beatIn    = (state_q == ST_COLLECT) && in_valid;
  assign popFire   = !fifoEmpty && mem_ready;
  assign pushFire  = beatIn && (!fifoFull || popFire);
  assign dropBeat  = beatIn && fifoFull && !popFire;

  always_comb begin
    wrPtr_d     = pushFire ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d     = popFire ? rdPtr_q + 1'b1 : rdPtr_q;
    fifoCount_d = fifoCount_q;
    case ({pushFire, popFire})
      2'b10:   fifoCount_d = fifoCount_q + 1'b1;
      2'b01:   fifoCount_d = fifoCount_q - 1'b1;
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  // Dropped beats still count so that a run always terminates.
  always_comb begin
    state_d    = state_q;
    beatCnt_d  = beatCnt_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_COLLECT;
          beatCnt_d  = '0;
          overflow_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          beatCnt_d = beatCnt_q + 1'b1;
          if (dropBeat) begin
            overflow_d = 1'b1;
          end
          if (beatCnt_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifoEmpty) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      beatCnt_q   <= '0;
      overflow_q  <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      state_q     <= state_d;
      beatCnt_q   <= beatCnt_d;
      overflow_q  <= overflow_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoCount_q <= fifoCount_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushFire) begin
      fifoMem_q[wrPtr_q] <= {entryAddr, in_data};
    end
  end

  assign headEntry = fifoMem_q[rdPtr_q];

  always_comb begin
    mem_we    = !fifoEmpty;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!fifoEmpty) begin
      mem_addr  = headEntry[ENTRY_W-1:DATA_WIDTH];
      mem_wdata = headEntry[DATA_WIDTH-1:0];
    end
  end

  assign busy       = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign overflow   = overflow_q;
  assign fifo_count = fifoCount_q;

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: a full-size instance for addressing and FIFO behaviour,
// and a tiny-map instance (2x2x2) for complete runs, both against a queue model.
module tb_output_collector;

  localparam int BW = 128, BH = 128, BC = 64;
  localparam int SW = 2, SH = 2, SC = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arstN;

  logic        bStart, bValid, bReady;
  logic [6:0]  bX, bY;
  logic [5:0]  bCh;
  logic [15:0] bData;
  logic        bWe, bBusy, bDone, bOvf;
  logic [19:0] bAddr;
  logic [15:0] bWdata;
  logic [3:0]  bCount;

  logic        sStart, sValid, sReady;
  logic        sX, sY, sCh;
  logic [15:0] sData;
  logic        sWe, sBusy, sDone, sOvf;
  logic [2:0]  sAddr;
  logic [15:0] sWdata;
  logic [3:0]  sCount;

  int checks = 0;
  int errors = 0;

  logic [35:0] bExp[$];
  logic [35:0] bWrites[$];
  logic [18:0] sExp[$];
  logic [18:0] sWrites[$];
  int   mOcc;
  logic mCollect, mOvf;
  int   sBeats;
  logic sCollect;

  output_collector #(
    .DATA_WIDTH(16), .FEATURE_MAP_WIDTH(BW), .FEATURE_MAP_HEIGHT(BH),
    .OUTPUT_NB_CHANNELS(BC), .FIFO_DEPTH(DEPTH)
  ) dutBig (
    .clk(clk), .arst_n(arstN), .start(bStart), .in_data(bData), .in_valid(bValid),
    .in_x(bX), .in_y(bY), .in_ch(bCh), .mem_we(bWe), .mem_addr(bAddr),
    .mem_wdata(bWdata), .mem_ready(bReady), .busy(bBusy), .done(bDone),
    .overflow(bOvf), .fifo_count(bCount)
  );

  output_collector #(
    .DATA_WIDTH(16), .FEATURE_MAP_WIDTH(SW), .FEATURE_MAP_HEIGHT(SH),
    .OUTPUT_NB_CHANNELS(SC), .FIFO_DEPTH(DEPTH)
  ) dutSmall (
    .clk(clk), .arst_n(arstN), .start(sStart), .in_data(sData), .in_valid(sValid),
    .in_x(sX), .in_y(sY), .in_ch(sCh), .mem_we(sWe), .mem_addr(sAddr),
    .mem_wdata(sWdata), .mem_ready(sReady), .busy(sBusy), .done(sDone),
    .overflow(sOvf), .fifo_count(sCount)
  );

  // Record every accepted memory write, sampled mid-cycle before the edge that commits it.
  always @(negedge clk) begin
    if (arstN && bWe && bReady) bWrites.push_back({bAddr, bWdata});
    if (arstN && sWe && sReady) sWrites.push_back({sAddr, sWdata});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    arstN = 1'b0;
    bStart = 1'b0; bValid = 1'b0; bReady = 1'b0;
    bX = '0; bY = '0; bCh = '0; bData = '0;
    sStart = 1'b0; sValid = 1'b0; sReady = 1'b1;
    sX = 1'b0; sY = 1'b0; sCh = 1'b0; sData = '0;
    step();
    step();
    arstN = 1'b1;
    mOcc = 0; mCollect = 1'b0; mOvf = 1'b0;
    sBeats = 0; sCollect = 1'b0;
    bExp.delete(); bWrites.delete(); sExp.delete(); sWrites.delete();
  endtask

  task automatic bStartRun();
    bStart = 1'b1;
    step();
    bStart = 1'b0;
    mCollect = 1'b1;
    mOvf = 1'b0;
  endtask

  // One cycle on the full-size instance; the model is a FIFO of pending writes.
  task automatic bCycle(input logic v, input logic [6:0] x, input logic [6:0] y,
                        input logic [5:0] ch, input logic [15:0] d);
    logic pop;
    int   addr;
    pop  = (mOcc > 0) && bReady;
    addr = int'(ch) * BW * BH + int'(y) * BW + int'(x);
    if (v && mCollect) begin
      if (mOcc < DEPTH || pop) begin
        bExp.push_back({addr[19:0], d});
        mOcc++;
      end else begin
        mOvf = 1'b1;
      end
    end
    if (pop) mOcc--;
    bValid = v; bX = x; bY = y; bCh = ch; bData = d;
    step();
    bValid = 1'b0;
  endtask

  task automatic bRandBeat(input logic v);
    bCycle(v, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
           6'($urandom_range(0, 63)), 16'($urandom));
  endtask

  task automatic bDrain();
    bReady = 1'b1;
    for (int i = 0; i < 3 * DEPTH && mOcc > 0; i++) bCycle(1'b0, '0, '0, '0, '0);
  endtask

  task automatic sCycle(input logic v, input logic x, input logic y, input logic ch,
                        input logic [15:0] d);
    int addr;
    addr = int'(ch) * SW * SH + int'(y) * SW + int'(x);
    if (v && sCollect) begin
      sExp.push_back({addr[2:0], d});
      sBeats++;
      if (sBeats == SW * SH * SC) sCollect = 1'b0;
    end
    sValid = v; sX = x; sY = y; sCh = ch; sData = d;
    step();
    sValid = 1'b0;
  endtask

  task automatic sRandBeat(input logic v);
    sCycle(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({bWe, bBusy, bDone, bOvf, bCount} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL resetBigStatus: got %h expected 00", {bWe, bBusy, bDone, bOvf, bCount});
    end
    checks++;
    if ({bAddr, bWdata} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL resetBigHead: got %h expected 0", {bAddr, bWdata});
    end
    checks++;
    if ({sWe, sBusy, sDone, sOvf, sCount} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL resetSmallStatus: got %h expected 00", {sWe, sBusy, sDone, sOvf, sCount});
    end
    bReady = 1'b1;
    for (int i = 0; i < 3; i++) bRandBeat(1'b1);
    step();
    checks++;
    if (bWe !== 1'b0 || bCount !== 4'd0 || bWrites.size() != 0) begin
      errors++;
      $display("[TB] FAIL idleIgnored: got we=%b count=%0d writes=%0d expected 0 0 0",
               bWe, bCount, bWrites.size());
    end
  endtask

  task automatic test_addressing();
    logic [6:0]  xs  [4] = '{7'd1, 7'd0, 7'd0, 7'd127};
    logic [6:0]  ys  [4] = '{7'd0, 7'd1, 7'd0, 7'd127};
    logic [5:0]  chs [4] = '{6'd0, 6'd0, 6'd1, 6'd63};
    logic [15:0] ds  [4] = '{16'd5, 16'hFFFD, 16'd7, 16'd1};
    logic [19:0] as  [4] = '{20'd1, 20'd128, 20'd16384, 20'd1048575};
    doReset();
    bStartRun();
    bReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bCycle(1'b1, xs[i], ys[i], chs[i], ds[i]);
      checks++;
      if (bWe !== 1'b1 || bAddr !== as[i] || bWdata !== ds[i]) begin
        errors++;
        $display("[TB] FAIL dirWrite[%0d]: got we=%b addr=%0d data=%h expected 1 %0d %h",
                 i, bWe, bAddr, bWdata, as[i], ds[i]);
      end
      checks++;
      if (bCount !== 4'd1) begin
        errors++;
        $display("[TB] FAIL dirCount[%0d]: got %0d expected 1", i, bCount);
      end
    end
    bCycle(1'b0, '0, '0, '0, '0);
    checks++;
    if (bWe !== 1'b0 || bCount !== 4'd0 || bWrites.size() != 4) begin
      errors++;
      $display("[TB] FAIL dirDrained: got we=%b count=%0d writes=%0d expected 0 0 4",
               bWe, bCount, bWrites.size());
    end
    for (int i = 0; i < 4 && i < bWrites.size(); i++) begin
      checks++;
      if (bWrites[i] !== {as[i], ds[i]}) begin
        errors++;
        $display("[TB] FAIL dirOrder[%0d]: got %h expected %h", i, bWrites[i], {as[i], ds[i]});
      end
    end
  endtask

  task automatic test_full_and_overflow();
    doReset();
    bStartRun();
    bReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) bRandBeat(1'b1);
    checks++;
    if (bCount !== 4'd8 || bOvf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fillToFull: got count=%0d ovf=%b expected 8 0", bCount, bOvf);
    end
    bReady = 1'b1;
    bRandBeat(1'b1);
    checks++;
    if (bCount !== 4'd8 || bOvf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fullPushPop: got count=%0d ovf=%b expected 8 0", bCount, bOvf);
    end
    bReady = 1'b0;
    bRandBeat(1'b1);
    checks++;
    if (bCount !== 4'd8 || bOvf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflowDrop: got count=%0d ovf=%b expected 8 1", bCount, bOvf);
    end
    bDrain();
    checks++;
    if (bWe !== 1'b0 || bWrites.size() != bExp.size() || bExp.size() != 9) begin
      errors++;
      $display("[TB] FAIL ovfWriteCount: got we=%b writes=%0d expected 0 %0d (model 9)",
               bWe, bWrites.size(), bExp.size());
    end
    for (int i = 0; i < bExp.size() && i < bWrites.size(); i++) begin
      checks++;
      if (bWrites[i] !== bExp[i]) begin
        errors++;
        $display("[TB] FAIL ovfOrder[%0d]: got %h expected %h", i, bWrites[i], bExp[i]);
      end
    end
  endtask

  task automatic test_random();
    doReset();
    bStartRun();
    for (int i = 0; i < 400; i++) begin
      bReady = ($urandom_range(0, 1) == 1);
      bRandBeat($urandom_range(0, 3) != 0);
      checks++;
      if (bCount !== mOcc[3:0] || bOvf !== mOvf || bWe !== (mOcc > 0)) begin
        errors++;
        $display("[TB] FAIL randState[%0d]: got count=%0d ovf=%b we=%b expected %0d %b %b",
                 i, bCount, bOvf, bWe, mOcc, mOvf, (mOcc > 0));
      end
    end
    bDrain();
    checks++;
    if (bWrites.size() != bExp.size()) begin
      errors++;
      $display("[TB] FAIL randWriteCount: got %0d expected %0d", bWrites.size(), bExp.size());
    end
    for (int i = 0; i < bExp.size() && i < bWrites.size(); i++) begin
      checks++;
      if (bWrites[i] !== bExp[i]) begin
        errors++;
        $display("[TB] FAIL randOrder[%0d]: got %h expected %h", i, bWrites[i], bExp[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    doReset();
    bStartRun();
    bReady = 1'b0;
    for (int i = 0; i < 3; i++) bRandBeat(1'b1);
    checks++;
    if (bCount !== 4'd3) begin
      errors++;
      $display("[TB] FAIL midrunFill: got %0d expected 3", bCount);
    end
    arstN = 1'b0;
    step();
    checks++;
    if ({bWe, bBusy, bCount} !== 6'h00) begin
      errors++;
      $display("[TB] FAIL midrunReset: got %h expected 00", {bWe, bBusy, bCount});
    end
    arstN = 1'b1;
    bReady = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bWe !== 1'b0 || bWrites.size() != 0) begin
      errors++;
      $display("[TB] FAIL midrunNoWrites: got we=%b writes=%0d expected 0 0", bWe, bWrites.size());
    end
  endtask

  task automatic test_small_run();
    doReset();
    sStart = 1'b1;
    step();
    sStart = 1'b0;
    sCollect = 1'b1; sBeats = 0;
    for (int i = 0; i < SW * SH * SC; i++) sRandBeat(1'b1);
    checks++;
    if (sBusy !== 1'b1 || sDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL smallDrain: got busy=%b done=%b expected 1 0", sBusy, sDone);
    end
    for (int i = 0; i < 2 && !sDone; i++) step();
    checks++;
    if (sDone !== 1'b1 || sBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL smallDone: got done=%b busy=%b expected 1 0", sDone, sBusy);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (sDone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL smallDoneHeld: got %b expected 1", sDone);
    end
    checks++;
    if (sWrites.size() != sExp.size() || sExp.size() != 8) begin
      errors++;
      $display("[TB] FAIL smallWriteCount: got %0d expected %0d", sWrites.size(), sExp.size());
    end
    for (int i = 0; i < sExp.size() && i < sWrites.size(); i++) begin
      checks++;
      if (sWrites[i] !== sExp[i]) begin
        errors++;
        $display("[TB] FAIL smallOrder[%0d]: got %h expected %h", i, sWrites[i], sExp[i]);
      end
    end
    sRandBeat(1'b1);
    sRandBeat(1'b1);
    step();
    checks++;
    if (sWe !== 1'b0 || sCount !== 4'd0 || sWrites.size() != 8) begin
      errors++;
      $display("[TB] FAIL doneIgnored: got we=%b count=%0d writes=%0d expected 0 0 8",
               sWe, sCount, sWrites.size());
    end
    sStart = 1'b1;
    step();
    sStart = 1'b0;
    sCollect = 1'b1; sBeats = 0;
    checks++;
    if (sDone !== 1'b0 || sBusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart: got done=%b busy=%b expected 0 1", sDone, sBusy);
    end
    for (int i = 0; i < 3; i++) sRandBeat(1'b1);
    sStart = 1'b1;
    step();
    sStart = 1'b0;
    for (int i = 0; i < 4; i++) sRandBeat(1'b1);
    step();
    checks++;
    if (sBusy !== 1'b1 || sDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL startIgnoredEarly: got busy=%b done=%b expected 1 0", sBusy, sDone);
    end
    sRandBeat(1'b1);
    for (int i = 0; i < 2 && !sDone; i++) step();
    checks++;
    if (sDone !== 1'b1 || sWrites.size() != 16) begin
      errors++;
      $display("[TB] FAIL startIgnoredDone: got done=%b writes=%0d expected 1 16",
               sDone, sWrites.size());
    end
  endtask

  initial begin
    arstN = 1'b0;
    bStart = 1'b0; bValid = 1'b0; bReady = 1'b0;
    bX = '0; bY = '0; bCh = '0; bData = '0;
    sStart = 1'b0; sValid = 1'b0; sReady = 1'b1;
    sX = 1'b0; sY = 1'b0; sCh = 1'b0; sData = '0;
    test_reset();
    test_addressing();
    test_full_and_overflow();
    test_random();
    test_reset_midrun();
    test_small_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
